// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared BCD definitions: FSM state encodings, digit constants and the per-digit unadjust rule.
// Used by both the BCD-to-binary converter and the binary-to-BCD display path.
package bcd_to_binary_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int         BCD_DIGIT_W    = 4;
   localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
   localparam logic [3:0] BCD_ADJ        = 4'd3;
   localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;

   // Inverse of the double-dabble +3 step: undo it once a digit has absorbed a shifted-in 8.
   function automatic logic [3:0] digit_unadjust(input logic [3:0] d);
      return (d >= BCD_ADJ_THRESH) ? d - BCD_ADJ : d;
   endfunction

endpackage

// File: rtl/bcd_to_binary_seq_unadjust.sv
// Combinational per-digit correction for reverse double dabble: out = (in >= 8) ? in-3 : in.
// Zero latency; no flow control.
module bcd_digit_unadjust
   import bcd_to_binary_seq_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] din,
   output logic [BCD_DIGIT_W-1:0] dout
);

   assign dout = digit_unadjust(din);

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble), one conversion at a time, start/ready/done framed.
// Latency BIN_W+1 edges (2 for rejected input when BCD2BIN_DIGIT_CHECK_EN is defined); start ignored unless ready.
module bcd_to_binary_seq
   import bcd_to_binary_seq_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
   output logic                          ready,
   output logic                          busy,
   output logic                          done,
   output logic [BIN_W-1:0]              bin_out,
   output logic                          err
);

   localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
   localparam int WORK_W = BCD_W + BIN_W;
   localparam int CNT_W  = $clog2(BIN_W + 1);

   state_t             state;
   logic [WORK_W-1:0]  work;
   logic [WORK_W-1:0]  shifted;
   logic [WORK_W-1:0]  next_work;
   logic [CNT_W-1:0]   cnt;
   logic               reject;

   assign shifted                = work >> 1;
   assign next_work[BIN_W-1:0]   = shifted[BIN_W-1:0];

   for (genvar g = 0; g < DIGITS; g++) begin : g_unadj
      bcd_digit_unadjust u_unadj (
         .din  (shifted[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .dout (next_work[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

`ifdef BCD2BIN_DIGIT_CHECK_EN
   logic bad_digit;
   logic err_r;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) bad_digit = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (state == ST_IDLE && start) begin
         err_r <= bad_digit;
      end
   end

   assign reject = bad_digit;
   assign err    = err_r;
`else
   assign reject = 1'b0;
   assign err    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         bin_out <= '0;
         work    <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  ready <= 1'b0;
                  if (reject) begin
                     bin_out <= '0;
                     state   <= ST_DONE;
                  end else begin
                     work  <= {bcd_in, {BIN_W{1'b0}}};
                     cnt   <= '0;
                     busy  <= 1'b1;
                     state <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               work <= next_work;
               cnt  <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(BIN_W - 1)) begin
                  bin_out <= next_work[BIN_W-1:0];
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               // A rejected input arrives here with done low and spends one extra cycle raising it.
               if (!done) begin
                  done <= 1'b1;
               end else begin
                  done  <= 1'b0;
                  ready <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Scoreboard bench for bcd_to_binary_seq: an acceptor pushes decimal-arithmetic expectations, a monitor pops on done.
// Covers directed cases plus randomized valid BCD operands.
module tb_bcd_to_binary_seq;

   localparam int DIGITS = 3;
   localparam int BIN_W  = 10;

   typedef struct {
      int  bin;
      bit  err;
      bit  chk_bin;
      int  acc_cyc;
      int  lat;
      int  busy_cycles;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [11:0]       bcd_in = '0;
   logic              ready, busy, done, err;
   logic [BIN_W-1:0]  bin_out;

   exp_t q[$];
   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;
   int   nacc = 0;
   int   ndone = 0;
   int   busy_cnt = 0;
   bit   gap_chk = 0;
   bit   have_prev = 0;
   int   prev_done = 0;

   bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
      .ready(ready), .busy(busy), .done(done), .bin_out(bin_out), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic bit is_valid(input logic [11:0] b);
      for (int i = 0; i < DIGITS; i++) if (b[i*4 +: 4] > 4'd9) return 0;
      return 1;
   endfunction

   function automatic int bcd2int(input logic [11:0] b);
      int v = 0;
      for (int i = DIGITS-1; i >= 0; i--) v = v*10 + int'(b[i*4 +: 4]);
      return v;
   endfunction

   // Acceptor: a start seen with ready high is taken on the next edge.
   always @(negedge clk) begin
      if (!rst && start && ready) begin
         exp_t e;
         bit   v;
         v = is_valid(bcd_in);
         e.acc_cyc = cyc + 1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
         e.err         = !v;
         e.bin         = v ? bcd2int(bcd_in) : 0;
         e.chk_bin     = 1;
         e.lat         = v ? BIN_W + 1 : 2;
         e.busy_cycles = v ? BIN_W : 0;
`else
         e.err         = 0;
         e.bin         = bcd2int(bcd_in);
         e.chk_bin     = v;
         e.lat         = BIN_W + 1;
         e.busy_cycles = BIN_W;
`endif
         q.push_back(e);
         nacc++;
         busy_cnt = 0;
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (busy) busy_cnt++;
         if (done) begin
            ndone++;
            if (q.size() == 0) begin
               chk("spurious_done", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (e.chk_bin) chk("bin_out", int'(bin_out), e.bin);
               chk("err", int'(err), int'(e.err));
               chk("latency", cyc - e.acc_cyc + 1, e.lat);
               chk("busy_cycles", busy_cnt, e.busy_cycles);
               if (gap_chk && have_prev) chk("done_spacing", cyc - prev_done, BIN_W + 2);
               prev_done = cyc;
               have_prev = 1;
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic conv(input logic [11:0] b);
      int n0;
      bit ok;
      bcd_in = b;
      start  = 1'b1;
      n0 = nacc;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk); #1;
         ok = (nacc != n0);
      end
      start  = 1'b0;
      bcd_in = 12'($urandom);
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(posedge clk); #1;
         ok = (q.size() == 0);
      end
      if (!ok) chk("drain_timeout", q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", int'({ready, busy, done, err, bin_out}), int'({1'b1, 1'b0, 1'b0, 1'b0, 10'd0}));
      rst = 1'b0;
      @(posedge clk); #1;

      conv(12'h255); drain();
      conv(12'h999); drain();
      conv(12'h000); drain();

      // Start re-pulsed during SHIFT must be ignored.
      d0 = ndone;
      conv(12'h042);
      for (int i = 0; i < 8; i++) begin
         bcd_in = 12'h123;
         start  = (i % 2 == 0);
         @(posedge clk); #1;
      end
      start = 1'b0;
      drain();
      chk("single_done", ndone - d0, 1);

      // Reset mid-conversion.
      d0 = ndone;
      conv(12'h777);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_outputs", int'({ready, busy, done, err, bin_out}), int'({1'b1, 1'b0, 1'b0, 1'b0, 10'd0}));
      q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_no_done", ndone - d0, 0);
      conv(12'h010); drain();

      // Invalid digit.
      conv(12'h1A5); drain();
      conv(12'h100); drain();

      // Start held high: back-to-back conversions.
      gap_chk   = 1;
      have_prev = 0;
      begin
         logic [11:0] seq [3];
         int n0;
         bit ok;
         seq[0] = 12'h001; seq[1] = 12'h500; seq[2] = 12'h998;
         start = 1'b1;
         for (int k = 0; k < 3; k++) begin
            bcd_in = seq[k];
            n0 = nacc;
            ok = 0;
            for (int i = 0; i < 40 && !ok; i++) begin
               @(posedge clk); #1;
               ok = (nacc != n0);
            end
            if (!ok) chk("b2b_accept_timeout", 0, 1);
         end
         bcd_in = 12'h321;
         for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
         end
         start = 1'b0;
      end
      drain();
      gap_chk = 0;

      // Randomized valid operands.
      for (int n = 0; n < 25; n++) begin
         logic [11:0] b;
         for (int i = 0; i < DIGITS; i++) b[i*4 +: 4] = 4'($urandom_range(0, 9));
         conv(b);
         if ($urandom_range(0, 1) == 1) drain();
      end
      drain();

      chk("scoreboard_empty", q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
